gamepad_pmod_driver: RTL and testbench

- Transmit side of the gamepad PMOD serial link that the Atari 2600 top level receives on ui_in (latch/clk/data).
- Snapshots a parallel vector of button states, shifts it out MSB first on a divided serial clock, then pulses latch so the receiver transfers its shift register to the joystick/console-switch inputs.
- Used as the stimulus generator in cocotb/Verilog benches and in FPGA bring-up wrappers feeding the top level.

---
 rtl/gamepad_pmod_pkg.sv | 29 ++
 rtl/gamepad_phase_timer.sv | 27 ++
 rtl/gamepad_pmod_driver.sv | 152 +++++++++++++++
 tb/tb_gamepad_pmod_driver.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gamepad_pmod_pkg.sv
// Shared types and constants for the gamepad PMOD serial transmitter.
package gamepad_pmod_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT_LO,
        SHIFT_HI,
        LATCH,
        GAP
    } state_t;

    localparam int CONTROLLER_BITS  = 12;
    localparam int DEFAULT_NUM_BITS = 2 * CONTROLLER_BITS;

    // Button positions within one controller's 12-bit field
    localparam int BTN_B      = 0;
    localparam int BTN_Y      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;
    localparam int BTN_A      = 8;
    localparam int BTN_X      = 9;
    localparam int BTN_L      = 10;
    localparam int BTN_R      = 11;

endpackage

// File: rtl/gamepad_phase_timer.sv
// Loadable down-counter timing each FSM phase; phase_end marks the last cycle.
module gamepad_phase_timer #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] len,
    output logic             phase_end
);

    logic [WIDTH-1:0] cnt;

    // Loading len gives a phase of len cycles, ending when the count reaches zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= len - 1'b1;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign phase_end = (cnt == '0);

endmodule

// File: rtl/gamepad_pmod_driver.sv
// Gamepad PMOD transmitter: snapshots buttons, shifts them MSB first on a
// divided serial clock, then pulses latch so the receiver updates its inputs.
module gamepad_pmod_driver
    import gamepad_pmod_pkg::*;
#(
    parameter int NUM_BITS   = DEFAULT_NUM_BITS,
    parameter int CLK_DIV    = 2,
    parameter int GAP_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                auto_repeat,
    input  logic [NUM_BITS-1:0] buttons,
    output logic                busy,
    output logic                done,
    output logic                pmod_data,
    output logic                pmod_clk,
    output logic                pmod_latch
);

    localparam int PHASE_MAX = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
    localparam int PW        = $clog2(PHASE_MAX + 1);
    localparam int BW        = $clog2(NUM_BITS);

    localparam logic [PW-1:0] DIV_LEN  = PW'(CLK_DIV);
    localparam logic [PW-1:0] GAP_LEN  = PW'(GAP_CYCLES);
    localparam logic [BW-1:0] LAST_BIT = BW'(NUM_BITS - 1);

    state_t              state;
    logic [NUM_BITS-1:0] shreg;
    logic [BW-1:0]       bit_cnt;
    logic                phase_end;
    logic                tm_load;
    logic [PW-1:0]       tm_len;
    logic                frame_exit;

    gamepad_phase_timer #(
        .WIDTH (PW)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (tm_load),
        .len       (tm_len),
        .phase_end (phase_end)
    );

    // End of a frame: last GAP cycle, or end of LATCH when there is no gap
    always_comb begin
        frame_exit = 1'b0;
        if (phase_end) begin
            if (state == GAP) begin
                frame_exit = 1'b1;
            end else if (state == LATCH && GAP_CYCLES == 0) begin
                frame_exit = 1'b1;
            end
        end
    end

    // Reload the phase timer on every state entry
    always_comb begin
        tm_load = 1'b0;
        tm_len  = DIV_LEN;
        case (state)
            IDLE:     tm_load = start | auto_repeat;
            SHIFT_LO: tm_load = phase_end;
            SHIFT_HI: tm_load = phase_end;
            LATCH: begin
                if (phase_end && GAP_CYCLES != 0) begin
                    tm_load = 1'b1;
                    tm_len  = GAP_LEN;
                end
            end
            default: ;
        endcase
        if (frame_exit && auto_repeat) begin
            tm_load = 1'b1;
            tm_len  = DIV_LEN;
        end
    end

    // Frame sequencer with registered serial outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            shreg      <= '0;
            bit_cnt    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pmod_data  <= 1'b0;
            pmod_clk   <= 1'b0;
            pmod_latch <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start || auto_repeat) begin
                        shreg     <= buttons;
                        bit_cnt   <= LAST_BIT;
                        pmod_data <= buttons[NUM_BITS-1];
                        busy      <= 1'b1;
                        state     <= SHIFT_LO;
                    end
                end
                SHIFT_LO: begin
                    if (phase_end) begin
                        pmod_clk <= 1'b1;
                        state    <= SHIFT_HI;
                    end
                end
                SHIFT_HI: begin
                    if (phase_end) begin
                        pmod_clk <= 1'b0;
                        if (bit_cnt != '0) begin
                            shreg     <= shreg << 1;
                            bit_cnt   <= bit_cnt - 1'b1;
                            pmod_data <= shreg[NUM_BITS-2];
                            state     <= SHIFT_LO;
                        end else begin
                            pmod_data  <= 1'b0;
                            pmod_latch <= 1'b1;
                            state      <= LATCH;
                        end
                    end
                end
                LATCH: begin
                    if (phase_end) begin
                        pmod_latch <= 1'b0;
                        done       <= 1'b1;
                        state      <= GAP;
                    end
                end
                GAP: ;
                default: state <= IDLE;
            endcase
            // Frame exit is shared by GAP and by a gapless LATCH, so it
            // overrides the per-state next state chosen above.
            if (frame_exit) begin
                if (auto_repeat) begin
                    shreg     <= buttons;
                    bit_cnt   <= LAST_BIT;
                    pmod_data <= buttons[NUM_BITS-1];
                    state     <= SHIFT_LO;
                end else begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            end
        end
    end

endmodule

// File: tb/tb_gamepad_pmod_driver.sv
// Self-checking bench for gamepad_pmod_driver using a serial receiver model
// and frame timing derived arithmetically from the parameters.
module tb_gamepad_pmod_driver;

    localparam int NB  = 24;
    localparam int CD  = 2;
    localparam int GC  = 4;
    localparam int NB2 = 12;
    localparam int CD2 = 1;
    localparam int GC2 = 0;
    localparam int FRAME     = NB * 2 * CD + CD + GC;
    localparam int DONE_REL  = NB * 2 * CD + CD + 1;
    localparam int FRAME2    = NB2 * 2 * CD2 + CD2 + GC2;
    localparam int DONE_REL2 = NB2 * 2 * CD2 + CD2 + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic          start = 1'b0, auto_repeat = 1'b0;
    logic [NB-1:0] buttons = '0;
    logic          busy, done, pmod_data, pmod_clk, pmod_latch;

    logic           start_s = 1'b0, auto_s = 1'b0;
    logic [NB2-1:0] buttons_s = '0;
    logic           busy_s, done_s, data_s, pclk_s, latch_s;

    gamepad_pmod_driver #(.NUM_BITS(NB), .CLK_DIV(CD), .GAP_CYCLES(GC)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .auto_repeat(auto_repeat),
        .buttons(buttons), .busy(busy), .done(done), .pmod_data(pmod_data),
        .pmod_clk(pmod_clk), .pmod_latch(pmod_latch)
    );

    gamepad_pmod_driver #(.NUM_BITS(NB2), .CLK_DIV(CD2), .GAP_CYCLES(GC2)) dut_s (
        .clk(clk), .rst_n(rst_n), .start(start_s), .auto_repeat(auto_s),
        .buttons(buttons_s), .busy(busy_s), .done(done_s), .pmod_data(data_s),
        .pmod_clk(pclk_s), .pmod_latch(latch_s)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t0 = 0;

    // Receiver and event statistics, main instance
    logic [NB-1:0] rx = '0;
    logic          pclk_q = 1'b0, pdata_q = 1'b0, latch_q = 1'b0;
    int            rises, rise_bad, latch_cyc, done_n, busy_n, data_viol;
    int            done_rel[$];
    logic [NB-1:0] caps[$];

    // Receiver and event statistics, reduced instance
    logic [NB2-1:0] rx_s = '0;
    logic           pclk_s_q = 1'b0, latch_s_q = 1'b0;
    int             rises_s, rise_bad_s, latch_cyc_s, done_n_s, busy_n_s;
    int             done_rel_s[$];
    logic [NB2-1:0] caps_s[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] cap_at(input int i);
        if (i < caps.size()) return 32'(caps[i]);
        return 32'hDEAD_BEEF;
    endfunction

    function automatic int done_at(input int i);
        if (i < done_rel.size()) return done_rel[i];
        return -1;
    endfunction

    task automatic clear_stats();
        t0 = cyc;
        rises = 0; rise_bad = 0; latch_cyc = 0; done_n = 0; busy_n = 0; data_viol = 0;
        done_rel.delete(); caps.delete();
        rises_s = 0; rise_bad_s = 0; latch_cyc_s = 0; done_n_s = 0; busy_n_s = 0;
        done_rel_s.delete(); caps_s.delete();
    endtask

    // Advance one clock and update both receiver models
    task automatic tick();
        int rel, f, k;
        @(posedge clk);
        #1;
        cyc++;
        rel = cyc - t0;
        if (busy) busy_n++;
        if (done) begin done_n++; done_rel.push_back(rel); end
        if (pmod_latch) latch_cyc++;
        if (pmod_latch && !latch_q) caps.push_back(rx);
        if (pmod_clk && !pclk_q) begin
            f = rises / NB;
            k = rises % NB;
            if (rel != f * FRAME + CD + 1 + 2 * CD * k) rise_bad++;
            rises++;
            rx = {rx[NB-2:0], pmod_data};
        end
        if (pmod_clk && pclk_q && pmod_data !== pdata_q) data_viol++;
        pclk_q = pmod_clk; pdata_q = pmod_data; latch_q = pmod_latch;

        if (busy_s) busy_n_s++;
        if (done_s) begin done_n_s++; done_rel_s.push_back(rel); end
        if (latch_s) latch_cyc_s++;
        if (latch_s && !latch_s_q) caps_s.push_back(rx_s);
        if (pclk_s && !pclk_s_q) begin
            f = rises_s / NB2;
            k = rises_s % NB2;
            if (rel != f * FRAME2 + CD2 + 1 + 2 * CD2 * k) rise_bad_s++;
            rises_s++;
            rx_s = {rx_s[NB2-2:0], data_s};
        end
        pclk_s_q = pclk_s; latch_s_q = latch_s;
    endtask

    task automatic check_single(input string tag, input logic [NB-1:0] exp_cap);
        check({tag, "_ncap"},   caps.size(), 1);
        check({tag, "_cap"},    cap_at(0), 32'(exp_cap));
        check({tag, "_busy"},   busy_n, FRAME);
        check({tag, "_ndone"},  done_n, 1);
        check({tag, "_done_t"}, done_at(0), DONE_REL);
        check({tag, "_rises"},  rises, NB);
        check({tag, "_rise_t"}, rise_bad, 0);
        check({tag, "_latch"},  latch_cyc, CD);
        check({tag, "_dstab"},  data_viol, 0);
    endtask

    task automatic run_single(input string tag, input logic [NB-1:0] b);
        clear_stats();
        buttons = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, "_lat1"}, busy, 1);
        repeat (FRAME + 10) tick();
        check_single(tag, b);
    endtask

    initial begin
        logic [31:0] r;
        logic [NB-1:0] b;

        // Reset state
        #12;
        check("rst_main_outs", {busy, done, pmod_data, pmod_clk, pmod_latch}, 0);
        check("rst_small_outs", {busy_s, done_s, data_s, pclk_s, latch_s}, 0);
        rst_n = 1'b1;
        repeat (3) tick();
        check("idle_busy", busy, 0);

        // Single frame
        run_single("single", 24'hA53C0F);

        // Snapshot held and start ignored while busy
        clear_stats();
        buttons = 24'hA53C0F;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (29) tick();
        buttons = 24'h000000;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (FRAME + 40) tick();
        check_single("snap", 24'hA53C0F);

        // Auto repeat, two back-to-back frames
        clear_stats();
        buttons = 24'h000001;
        auto_repeat = 1'b1;
        repeat (50) tick();
        buttons = 24'h800000;
        repeat (100) tick();
        auto_repeat = 1'b0;
        repeat (FRAME + 20) tick();
        check("auto_ncap",   caps.size(), 2);
        check("auto_cap0",   cap_at(0), 32'h000001);
        check("auto_cap1",   cap_at(1), 32'h800000);
        check("auto_ndone",  done_n, 2);
        check("auto_done0",  done_at(0), DONE_REL);
        check("auto_done1",  done_at(1), DONE_REL + FRAME);
        check("auto_busy",   busy_n, 2 * FRAME);
        check("auto_rises",  rises, 2 * NB);
        check("auto_rise_t", rise_bad, 0);
        check("auto_latch",  latch_cyc, 2 * CD);
        check("auto_dstab",  data_viol, 0);

        // Reset mid-frame
        clear_stats();
        r = $urandom();
        buttons = r[NB-1:0];
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (39) tick();
        rst_n = 1'b0;
        #1;
        check("midrst_outs", {busy, done, pmod_data, pmod_clk, pmod_latch}, 0);
        repeat (5) tick();
        check("midrst_hold", {busy, done, pmod_data, pmod_clk, pmod_latch}, 0);
        check("midrst_nolatch", latch_cyc, 0);
        check("midrst_ncap", caps.size(), 0);
        rst_n = 1'b1;
        repeat (2) tick();
        run_single("postrst", 24'h5A5A5A);

        // Randomized single frames
        for (int i = 0; i < 4; i++) begin
            r = $urandom();
            b = r[NB-1:0];
            run_single($sformatf("rand%0d", i), b);
        end

        // Reduced configuration: CLK_DIV=1, no gap, 12 bits
        for (int i = 0; i < 3; i++) begin
            clear_stats();
            if (i == 0) begin
                buttons_s = 12'hFFF;
            end else begin
                r = $urandom();
                buttons_s = r[NB2-1:0];
            end
            start_s = 1'b1;
            tick();
            start_s = 1'b0;
            repeat (FRAME2 + 8) tick();
            check($sformatf("small%0d_ncap", i), caps_s.size(), 1);
            check($sformatf("small%0d_cap", i),
                  (caps_s.size() > 0) ? 32'(caps_s[0]) : 32'hDEAD_BEEF, 32'(buttons_s));
            check($sformatf("small%0d_busy", i), busy_n_s, FRAME2);
            check($sformatf("small%0d_done", i),
                  (done_rel_s.size() > 0) ? done_rel_s[0] : -1, DONE_REL2);
            check($sformatf("small%0d_rises", i), rises_s, NB2);
            check($sformatf("small%0d_rise_t", i), rise_bad_s, 0);
            check($sformatf("small%0d_latch", i), latch_cyc_s, CD2);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
